// File: rtl/fir_sample_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fir_sample_capture_pkg
// Description : Shared definitions for the FIR sample capture block: default
//               sample width, buffer depth, address width and the capture FSM
//               state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package fir_sample_capture_pkg;

  localparam int N_DEF     = 16;  // sample width, matches fir_filter data width
  localparam int DEPTH_DEF = 32;  // capture buffer entries (power of two)
  localparam int AW_DEF    = 5;   // log2(DEPTH_DEF)

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } cap_state_t;

endpackage : fir_sample_capture_pkg
`default_nettype wire

// File: rtl/fir_sample_capture_if.sv
`default_nettype none
// ============================================================================
// Module      : fir_sample_capture_if
// Description : Stream/readback bundle between a sample producer (master) and
//               the capture block (slave).
//   sample_in    master->slave  N     signed filter output sample
//   sample_valid master->slave  1     sample_in valid this cycle
//   arm          master->slave  1     start-capture request
//   rd_addr      master->slave  AW    readback address
//   rd_data      slave->master  N     mem[rd_addr], 1-cycle latency
//   wr_addr      slave->master  AW    next write slot
//   busy / done  slave->master  1     capture in progress / capture complete
//   peak_max/min slave->master  N     signed extremes of current/last capture
//   zc_count     slave->master  AW+1  sign changes within the capture
// Revision    : 1.0 - initial release
// ============================================================================
interface fir_sample_capture_if #(
  parameter int N  = fir_sample_capture_pkg::N_DEF,
  parameter int AW = fir_sample_capture_pkg::AW_DEF
);

  logic [N-1:0]  sample_in;
  logic          sample_valid;
  logic          arm;
  logic [AW-1:0] rd_addr;
  logic [N-1:0]  rd_data;
  logic [AW-1:0] wr_addr;
  logic          busy;
  logic          done;
  logic [N-1:0]  peak_max;
  logic [N-1:0]  peak_min;
  logic [AW:0]   zc_count;

  modport master (
    output sample_in, sample_valid, arm, rd_addr,
    input  rd_data, wr_addr, busy, done, peak_max, peak_min, zc_count
  );

  modport slave (
    input  sample_in, sample_valid, arm, rd_addr,
    output rd_data, wr_addr, busy, done, peak_max, peak_min, zc_count
  );

endinterface : fir_sample_capture_if
`default_nettype wire

// File: rtl/fir_capture_ram.sv
`default_nettype none
// ============================================================================
// Module      : fir_capture_ram
// Description : DEPTH x N capture buffer. One synchronous write port and one
//               registered read port; a read of the address being written in
//               the same cycle returns the old contents. Storage is never
//               reset, only the read data register is.
//   clk       in   1    rising-edge clock
//   reset     in   1    synchronous active-low reset (read register only)
//   we_i      in   1    write enable
//   waddr_i   in   AW   write address
//   wdata_i   in   N    write data
//   raddr_i   in   AW   read address
//   rdata_o   out  N    registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module fir_capture_ram #(
  parameter int N     = 16,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  wire logic          clk,
  input  wire logic          reset,
  input  wire logic          we_i,
  input  wire logic [AW-1:0] waddr_i,
  input  wire logic [N-1:0]  wdata_i,
  input  wire logic [AW-1:0] raddr_i,
  output logic      [N-1:0]  rdata_o
);

  logic [N-1:0] mem_q [DEPTH];
  logic [N-1:0] rdata_q;

  // Storage kept out of any reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule : fir_capture_ram
`default_nettype wire

// File: rtl/fir_sample_capture.sv
`default_nettype none
// ============================================================================
// Module      : fir_sample_capture
// Description : Sink end of the FIR sample stream. After an arm pulse it
//               stores DEPTH consecutive valid samples, tracks the signed
//               peak max/min and then holds the results for readback.
//   clk    in     1   rising-edge clock
//   reset  in     1   synchronous active-low reset
//   bus    slave      fir_sample_capture_if (stream in, status and readback out)
// Configuration macro:
//   FIR_CAPTURE_ZC_EN - when defined, zc_count counts sign changes between
//                       consecutive captured samples; otherwise it reads 0.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_sample_capture
  import fir_sample_capture_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input wire logic          clk,
  input wire logic          reset,
  fir_sample_capture_if.slave bus
);

  cap_state_t            state_q;
  logic [AW-1:0]         wr_addr_q;
  logic signed [N-1:0]   peak_max_q;
  logic signed [N-1:0]   peak_min_q;
  logic                  first_q;     // next captured sample is the first of its capture
  logic                  busy_q;
  logic                  done_q;

  logic                  w_we;
  logic                  w_last;
  logic signed [N-1:0]   w_sample;

`ifdef FIR_CAPTURE_ZC_EN
  logic [AW:0]           zc_q;
  logic                  prev_neg_q;  // sign bit of the previously captured sample
`endif

  assign w_sample = $signed(bus.sample_in);
  assign w_we     = (state_q == ST_CAPTURE) && bus.sample_valid;
  assign w_last   = (wr_addr_q == AW'(DEPTH - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      wr_addr_q  <= '0;
      peak_max_q <= '0;
      peak_min_q <= '0;
      first_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef FIR_CAPTURE_ZC_EN
      zc_q       <= '0;
      prev_neg_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_CAPTURE: begin
          // arm is deliberately ignored here; only valid samples advance.
          if (bus.sample_valid) begin
            wr_addr_q <= wr_addr_q + 1'b1;  // wraps DEPTH-1 -> 0 naturally
            first_q   <= 1'b0;
            if (first_q) begin
              peak_max_q <= w_sample;
              peak_min_q <= w_sample;
            end else begin
              if (w_sample > peak_max_q) peak_max_q <= w_sample;
              if (w_sample < peak_min_q) peak_min_q <= w_sample;
            end
`ifdef FIR_CAPTURE_ZC_EN
            // Zero has a clear sign bit, so it counts as positive.
            prev_neg_q <= w_sample[N-1];
            if (!first_q && (w_sample[N-1] != prev_neg_q)) begin
              zc_q <= zc_q + 1'b1;
            end
`endif
            if (w_last) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          // IDLE, DONE (and the unused encoding) wait for arm. Peaks are
          // held until the first sample of the new capture re-seeds them.
          if (bus.arm) begin
            state_q   <= ST_CAPTURE;
            wr_addr_q <= '0;
            first_q   <= 1'b1;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
`ifdef FIR_CAPTURE_ZC_EN
            zc_q      <= '0;
`endif
          end
        end
      endcase
    end
  end

  fir_capture_ram #(
    .N     (N),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .we_i    (w_we),
    .waddr_i (wr_addr_q),
    .wdata_i (bus.sample_in),
    .raddr_i (bus.rd_addr),
    .rdata_o (bus.rd_data)
  );

  assign bus.wr_addr  = wr_addr_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.peak_max = peak_max_q;
  assign bus.peak_min = peak_min_q;
`ifdef FIR_CAPTURE_ZC_EN
  assign bus.zc_count = zc_q;
`else
  assign bus.zc_count = '0;
`endif

endmodule : fir_sample_capture
`default_nettype wire

// File: tb/tb_fir_sample_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_sample_capture
// Description : Self-checking bench for fir_sample_capture. A behavioural
//               model tracks state, write slot, peaks, zero crossings and the
//               buffer contents; readback expectations go through a queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_sample_capture;

  localparam int N     = 16;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
`ifdef FIR_CAPTURE_ZC_EN
  localparam bit ZC_EN = 1'b1;
`else
  localparam bit ZC_EN = 1'b0;
`endif

  typedef logic signed [31:0] val_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  fir_sample_capture_if #(.N(N), .AW(AW)) bus ();

  fir_sample_capture #(
    .N     (N),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  // Behavioural model (0=IDLE 1=CAPTURE 2=DONE)
  int           m_state;
  int           m_wr;
  int           m_max;
  int           m_min;
  int           m_zc;
  bit           m_first;
  bit           m_prev_neg;
  logic [N-1:0] m_mem [DEPTH];
  bit           m_vld [DEPTH];
  val_t         exp_q [$];

  task automatic check(input string tag, input val_t obs, input val_t exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_status();
    check("busy",     val_t'(bus.busy), val_t'(m_state == 1));
    check("done",     val_t'(bus.done), val_t'(m_state == 2));
    check("wr_addr",  val_t'(bus.wr_addr), val_t'(m_wr));
    check("peak_max", val_t'($signed(bus.peak_max)), val_t'(m_max));
    check("peak_min", val_t'($signed(bus.peak_min)), val_t'(m_min));
    check("zc_count", val_t'(bus.zc_count), ZC_EN ? val_t'(m_zc) : val_t'(0));
  endtask

  task automatic model_step(input bit a, input bit v, input logic [N-1:0] s);
    int sv;
    sv = int'($signed(s));
    if (m_state == 1) begin
      if (v) begin
        m_mem[m_wr] = s;
        m_vld[m_wr] = 1'b1;
        if (m_first) begin
          m_max = sv;
          m_min = sv;
        end else begin
          if (sv > m_max) m_max = sv;
          if (sv < m_min) m_min = sv;
          if (s[N-1] != m_prev_neg) m_zc++;
        end
        m_prev_neg = s[N-1];
        m_first    = 1'b0;
        if (m_wr == DEPTH - 1) begin
          m_wr    = 0;
          m_state = 2;
        end else begin
          m_wr++;
        end
      end
    end else if (a) begin
      m_state = 1;
      m_wr    = 0;
      m_zc    = 0;
      m_first = 1'b1;
    end
  endtask

  // One clock of stimulus; the readback expectation is taken before the
  // model applies this cycle's write, so same-address reads expect old data.
  task automatic cyc(input bit a, input bit v, input logic [N-1:0] s, input int ra);
    bit pushed;
    bus.arm          = a;
    bus.sample_valid = v;
    bus.sample_in    = s;
    bus.rd_addr      = AW'(ra);
    pushed           = 1'b0;
    if (m_vld[ra]) begin
      exp_q.push_back(val_t'(m_mem[ra]));
      pushed = 1'b1;
    end
    model_step(a, v, s);
    tick();
    if (pushed) check("rd_data", val_t'(bus.rd_data), exp_q.pop_front());
    check_status();
  endtask

  task automatic do_reset();
    reset            = 1'b0;
    bus.arm          = 1'b0;
    bus.sample_valid = 1'b0;
    bus.sample_in    = '0;
    tick();
    tick();
    m_state = 0;
    m_wr    = 0;
    m_max   = 0;
    m_min   = 0;
    m_zc    = 0;
    m_first = 1'b1;
    check("rst_busy",    val_t'(bus.busy), 0);
    check("rst_done",    val_t'(bus.done), 0);
    check("rst_wr_addr", val_t'(bus.wr_addr), 0);
    check("rst_rd_data", val_t'(bus.rd_data), 0);
    check("rst_pk_max",  val_t'(bus.peak_max), 0);
    check("rst_pk_min",  val_t'(bus.peak_min), 0);
    check("rst_zc",      val_t'(bus.zc_count), 0);
    reset = 1'b1;
  endtask

  task automatic readback_all();
    for (int a = 0; a < DEPTH; a++) cyc(1'b0, 1'b0, '0, a);
  endtask

  initial begin
    int vals [5];
    vals = '{-1000, 1200, -32768, 32767, 0};
    for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
    bus.rd_addr = '0;

    // 1: reset from power-up
    do_reset();

    // 2: ramp 0..31; sample on the arm cycle is not captured
    cyc(1'b1, 1'b1, N'(16'h1234), 0);
    for (int k = 0; k < DEPTH; k++) begin
      cyc(1'b0, 1'b1, N'(k), 0);
      if (k == DEPTH - 2) check("t2_done_early", val_t'(bus.done), 0);
    end
    check("t2_done",    val_t'(bus.done), 1);
    check("t2_busy",    val_t'(bus.busy), 0);
    check("t2_wr_addr", val_t'(bus.wr_addr), 0);
    check("t2_pk_max",  val_t'($signed(bus.peak_max)), 31);
    check("t2_pk_min",  val_t'($signed(bus.peak_min)), 0);
    cyc(1'b0, 1'b0, '0, 5);
    check("t2_rd5", val_t'(bus.rd_data), 5);
    readback_all();

    // 3: valid every other cycle, gap samples carry 7777
    cyc(1'b1, 1'b0, '0, 31);
    for (int k = 0; k < DEPTH; k++) begin
      if (k == DEPTH - 1) check("t3_done_before_last", val_t'(bus.done), 0);
      cyc(1'b0, 1'b1, N'(100 + k), 31);
      cyc(1'b0, 1'b0, N'(7777), 31);
    end
    check("t3_done", val_t'(bus.done), 1);
    check("t3_mem31", val_t'(bus.rd_data), 131);
    readback_all();

    // 4: signed extremes; rd_addr follows wr_addr to read old data on write
    cyc(1'b1, 1'b0, '0, 0);
    for (int k = 0; k < DEPTH; k++) begin
      if (k < 5) cyc(1'b0, 1'b1, N'(vals[k]), m_wr);
      else       cyc(1'b0, 1'b1, N'(3 * k), m_wr);
    end
    check("t4_pk_min", val_t'($signed(bus.peak_min)), -32768);
    check("t4_pk_max", val_t'($signed(bus.peak_max)), 32767);
    cyc(1'b1, 1'b0, '0, 2);
    check("t4_pk_held", val_t'($signed(bus.peak_min)), -32768);
    for (int k = 0; k < DEPTH; k++) cyc(1'b0, 1'b1, N'(5), 2);
    check("t4_pk5_max", val_t'($signed(bus.peak_max)), 5);
    check("t4_pk5_min", val_t'($signed(bus.peak_min)), 5);

    // 5: reset mid-capture, then a full capture with stray arm pulses
    cyc(1'b1, 1'b0, '0, 0);
    for (int k = 0; k < 10; k++) cyc(1'b0, 1'b1, N'(200 + k), 0);
    check("t5_wr10", val_t'(bus.wr_addr), 10);
    do_reset();
    cyc(1'b0, 1'b1, N'(55), 0);
    cyc(1'b1, 1'b0, '0, 0);
    for (int k = 0; k < DEPTH; k++) begin
      cyc((k == 5) || (k == 17), 1'b1, N'(300 + k), 7);
      if (k == 5) check("t5_arm_ignored", val_t'(bus.wr_addr), 6);
    end
    check("t5_done", val_t'(bus.done), 1);

    // 6: alternating +100/-100
    cyc(1'b1, 1'b0, '0, 0);
    for (int k = 0; k < DEPTH; k++) cyc(1'b0, 1'b1, (k % 2 == 0) ? N'(100) : N'(-100), 0);
    check("t6_zc", val_t'(bus.zc_count), ZC_EN ? val_t'(31) : val_t'(0));
    check("t6_done", val_t'(bus.done), 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_fir_sample_capture
`default_nettype wire
